// File: rtl/dram_arbiter_pkg.sv
// Shared encodings for the data_ram arbiter: FSM states, master IDs and bus constants.
package dram_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle   = 2'd0,
    ArbAccess = 2'd1,
    ArbResp   = 2'd2,
    ArbLocked = 2'd3
  } arb_state_e;

  localparam logic Master0 = 1'b0;
  localparam logic Master1 = 1'b1;

  localparam logic ChipEnable   = 1'b1;
  localparam logic ChipDisable  = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam int unsigned RegBus = 32;

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way round-robin pick: on a tie the master that was not granted last wins.
module arb_rr_pick
  import dram_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = req0 | req1;
    winner = Master0;
    if (req0 && req1) begin
      winner = (last_gnt == Master0) ? Master1 : Master0;
    end else if (req1) begin
      winner = Master1;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing data_ram between the CPU port (m0) and a bus master (m1).
// Define DRAM_ARB_LOCK_EN to add m0_lock_i/m1_lock_i for back-to-back locked bursts.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [SEL_W-1:0]  m0_sel_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [SEL_W-1:0]  m1_sel_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,
`ifdef DRAM_ARB_LOCK_EN
  input  logic              m0_lock_i,
  input  logic              m1_lock_i,
`endif
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [SEL_W-1:0]  ram_sel_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  arb_state_e        state_q, state_d;
  logic              last_gnt_q, cur_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;

  logic pick_valid, pick_winner;
  logic grant, gnt_id, upd_last;
  logic in_access, in_resp;

  arb_rr_pick u_pick (
    .req0     (m0_req_i),
    .req1     (m1_req_i),
    .last_gnt (last_gnt_q),
    .valid    (pick_valid),
    .winner   (pick_winner)
  );

`ifdef DRAM_ARB_LOCK_EN
  logic cur_req, cur_lock;
  assign cur_req  = (cur_q == Master1) ? m1_req_i  : m0_req_i;
  assign cur_lock = (cur_q == Master1) ? m1_lock_i : m0_lock_i;
`endif

  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    gnt_id   = pick_winner;
    upd_last = 1'b0;
    unique case (state_q)
      ArbIdle: begin
        if (pick_valid) begin
          grant    = 1'b1;
          upd_last = 1'b1;
          state_d  = ArbAccess;
        end
      end
      ArbAccess: state_d = ArbResp;
      ArbResp: begin
        state_d = ArbIdle;
`ifdef DRAM_ARB_LOCK_EN
        if (cur_lock) state_d = ArbLocked;
`endif
      end
      ArbLocked: begin
        state_d = ArbIdle;
`ifdef DRAM_ARB_LOCK_EN
        // Locked re-grants bypass round-robin and leave last_gnt alone.
        gnt_id = cur_q;
        if (cur_req && cur_lock) begin
          grant   = 1'b1;
          state_d = ArbAccess;
        end
`endif
      end
      default: state_d = ArbIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ArbIdle;
      last_gnt_q <= Master1;
      cur_q      <= Master0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      sel_q      <= '0;
      data_q     <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        cur_q  <= gnt_id;
        we_q   <= (gnt_id == Master1) ? m1_we_i   : m0_we_i;
        addr_q <= (gnt_id == Master1) ? m1_addr_i : m0_addr_i;
        sel_q  <= (gnt_id == Master1) ? m1_sel_i  : m0_sel_i;
        data_q <= (gnt_id == Master1) ? m1_data_i : m0_data_i;
      end
      if (upd_last) last_gnt_q <= gnt_id;
      // Read data is captured on the edge that ends ACCESS.
      if (in_access && !we_q) begin
        if (cur_q == Master1) m1_rdata_q <= ram_data_i;
        else                  m0_rdata_q <= ram_data_i;
      end
    end
  end

  assign in_access = (state_q == ArbAccess);
  assign in_resp   = (state_q == ArbResp);

  assign ram_ce_o   = in_access ? ChipEnable : ChipDisable;
  assign ram_we_o   = in_access ? we_q : WriteDisable;
  assign ram_addr_o = in_access ? addr_q : '0;
  assign ram_sel_o  = in_access ? sel_q  : '0;
  assign ram_data_o = in_access ? data_q : '0;

  assign m0_ack_o  = in_resp && (cur_q == Master0);
  assign m1_ack_o  = in_resp && (cur_q == Master1);
  assign m0_data_o = m0_rdata_q;
  assign m1_data_o = m1_rdata_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter with a behavioural data_ram (DRAM_ARB_LOCK_EN adds a lock test).
module tb_dram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;
`ifdef DRAM_ARB_LOCK_EN
  logic        m0_lock, m1_lock;
`endif

  always #5 clk = ~clk;

  dram_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .m0_req_i   (m0_req),
    .m0_we_i    (m0_we),
    .m0_addr_i  (m0_addr),
    .m0_sel_i   (m0_sel),
    .m0_data_i  (m0_wdata),
    .m0_data_o  (m0_rdata),
    .m0_ack_o   (m0_ack),
    .m1_req_i   (m1_req),
    .m1_we_i    (m1_we),
    .m1_addr_i  (m1_addr),
    .m1_sel_i   (m1_sel),
    .m1_data_i  (m1_wdata),
    .m1_data_o  (m1_rdata),
    .m1_ack_o   (m1_ack),
`ifdef DRAM_ARB_LOCK_EN
    .m0_lock_i  (m0_lock),
    .m1_lock_i  (m1_lock),
`endif
    .ram_ce_o   (ram_ce),
    .ram_we_o   (ram_we),
    .ram_addr_o (ram_addr),
    .ram_sel_o  (ram_sel),
    .ram_data_o (ram_wdata),
    .ram_data_i (ram_rdata)
  );

  // data_ram: combinational read, byte-masked write on the clock edge
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  assign ram_rdata = mem[ram_addr[7:2]];
  always @(posedge clk) begin
    if (ram_ce && ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_sel[b]) mem[ram_addr[7:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end
    end
  end

  typedef struct {
    int          m;
    bit          we;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   prev_ack_cyc = -1;
  bit   spacing_chk = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input int m, input bit we, input logic [31:0] addr,
                      input logic [3:0] sel, input logic [31:0] data);
    exp_t x;
    x.m  = m;
    x.we = we;
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (sel[b]) ref_mem[addr[7:2]][b*8 +: 8] = data[b*8 +: 8];
      end
      x.data = '0;
    end else begin
      x.data = ref_mem[addr[7:2]];
    end
    sb.push_back(x);
  endtask

  task automatic set_m(input int m, input logic req, input logic we, input logic [31:0] addr,
                       input logic [3:0] sel, input logic [31:0] data);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_sel = sel; m0_wdata = data;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_sel = sel; m1_wdata = data;
    end
  endtask

  task automatic wait_ack(input int m, input string tag);
    int  n = 0;
    bit  seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = (m == 0) ? m0_ack : m1_ack;
    end
    check_eq(tag, {31'b0, seen}, 32'd1);
  endtask

  // Waits for n acks (bounded), then withdraws both requests at the last ack.
  task automatic run_acks(input int n, input string tag);
    int got = 0;
    int k = 0;
    while (got < n && k < 60) begin
      @(negedge clk);
      k++;
      if (m0_ack || m1_ack) got++;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    check_eq(tag, got, n);
  endtask

  // Every ack is matched against the scoreboard head.
  always @(negedge clk) begin
    cyc++;
    if (m0_ack || m1_ack) begin
      if (sb.size() == 0) begin
        check_eq("spurious_ack", {30'b0, m1_ack, m0_ack}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("ack_id", {30'b0, m1_ack, m0_ack}, (e.m == 0) ? 32'd1 : 32'd2);
        if (!e.we) check_eq("rdata", (e.m == 0) ? m0_rdata : m1_rdata, e.data);
      end
      if (spacing_chk && prev_ack_cyc >= 0) check_eq("ack_spacing", cyc - prev_ack_cyc, 32'd3);
      prev_ack_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
    mem[4] = 32'hDEAD_BEEF;
    mem[8] = 32'h1122_3344;
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
    set_m(0, 1'b0, 1'b0, '0, '0, '0);
    set_m(1, 1'b0, 1'b0, '0, '0, '0);
`ifdef DRAM_ARB_LOCK_EN
    m0_lock = 1'b0;
    m1_lock = 1'b0;
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check_eq("rst_ce", {31'b0, ram_ce}, 32'd0);
    check_eq("rst_we", {31'b0, ram_we}, 32'd0);
    check_eq("rst_addr", ram_addr, 32'd0);
    check_eq("rst_ack", {30'b0, m1_ack, m0_ack}, 32'd0);
    check_eq("rst_m0_data", m0_rdata, 32'd0);
    check_eq("rst_m1_data", m1_rdata, 32'd0);

    // Single read by m0: ACCESS one cycle after the sampling edge, ack the next.
    @(posedge clk); #1;
    set_m(0, 1'b1, 1'b0, 32'h10, 4'hF, '0);
    push(0, 1'b0, 32'h10, 4'hF, '0);
    @(negedge clk);
    check_eq("ce_before_grant", {31'b0, ram_ce}, 32'd0);
    @(negedge clk);
    check_eq("ce_access", {31'b0, ram_ce}, 32'd1);
    check_eq("addr_access", ram_addr, 32'h10);
    check_eq("we_access", {31'b0, ram_we}, 32'd0);
    @(negedge clk);
    check_eq("m0_ack_latency", {31'b0, m0_ack}, 32'd1);
    check_eq("m1_ack_quiet", {31'b0, m1_ack}, 32'd0);
    check_eq("ce_resp", {31'b0, ram_ce}, 32'd0);
    m0_req = 1'b0;

    // m1 byte write, then read back.
    @(posedge clk); #1;
    set_m(1, 1'b1, 1'b1, 32'h20, 4'b0001, 32'h0000_00AB);
    push(1, 1'b1, 32'h20, 4'b0001, 32'h0000_00AB);
    wait_ack(1, "wr_ack");
    check_eq("wr_keeps_rdata", m1_rdata, 32'd0);
    m1_req = 1'b0;
    @(posedge clk); #1;
    set_m(1, 1'b1, 1'b0, 32'h20, 4'hF, '0);
    push(1, 1'b0, 32'h20, 4'hF, '0);
    wait_ack(1, "rd_ack");
    check_eq("byte_merge", m1_rdata, 32'h1122_33AB);
    m1_req = 1'b0;

    // Both requesting right after reset: m0, m1, m0, m1 at 3-cycle spacing.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    set_m(0, 1'b1, 1'b0, 32'h10, 4'hF, '0);
    set_m(1, 1'b1, 1'b0, 32'h20, 4'hF, '0);
    push(0, 1'b0, 32'h10, 4'hF, '0);
    push(1, 1'b0, 32'h20, 4'hF, '0);
    push(0, 1'b0, 32'h10, 4'hF, '0);
    push(1, 1'b0, 32'h20, 4'hF, '0);
    prev_ack_cyc = -1;
    spacing_chk = 1'b1;
    run_acks(4, "rr_acks");
    spacing_chk = 1'b0;

    // Reset in ACCESS after an m0 grant: ce drops at once and m0 still wins the next tie.
    @(posedge clk); #1;
    set_m(0, 1'b1, 1'b0, 32'h10, 4'hF, '0);
    @(negedge clk);
    @(negedge clk);
    check_eq("ce_pre_reset", {31'b0, ram_ce}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("ce_async_drop", {31'b0, ram_ce}, 32'd0);
    check_eq("no_ack_reset", {30'b0, m1_ack, m0_ack}, 32'd0);
    m0_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    check_eq("rdata_cleared", m0_rdata, 32'd0);
    set_m(0, 1'b1, 1'b0, 32'h10, 4'hF, '0);
    set_m(1, 1'b1, 1'b0, 32'h20, 4'hF, '0);
    push(0, 1'b0, 32'h10, 4'hF, '0);
    push(1, 1'b0, 32'h20, 4'hF, '0);
    run_acks(2, "post_reset_acks");

    // m1 withdraws during ACCESS: its ack still comes, then m0 is served.
    @(posedge clk); #1;
    set_m(1, 1'b1, 1'b0, 32'h10, 4'hF, '0);
    push(1, 1'b0, 32'h10, 4'hF, '0);
    @(negedge clk);
    @(negedge clk);
    m1_req = 1'b0;
    set_m(0, 1'b1, 1'b0, 32'h20, 4'hF, '0);
    push(0, 1'b0, 32'h20, 4'hF, '0);
    run_acks(2, "withdraw_acks");

`ifdef DRAM_ARB_LOCK_EN
    // m1 holds lock for three accesses while m0 waits.
    begin
      int m1_cnt = 0;
      int k = 0;
      int gap = 0;
      bit done = 1'b0;
      @(posedge clk); #1;
      set_m(1, 1'b1, 1'b0, 32'h20, 4'hF, '0);
      m1_lock = 1'b1;
      set_m(0, 1'b1, 1'b0, 32'h10, 4'hF, '0);
      for (int i = 0; i < 3; i++) push(1, 1'b0, 32'h20, 4'hF, '0);
      push(0, 1'b0, 32'h10, 4'hF, '0);
      while (!done && k < 60) begin
        @(negedge clk);
        k++;
        if (m1_cnt == 3) gap++;
        if (m1_ack) begin
          m1_cnt++;
          if (m1_cnt == 3) begin
            m1_req  = 1'b0;
            m1_lock = 1'b0;
          end
        end
        if (m0_ack) begin
          m0_req = 1'b0;
          done   = 1'b1;
        end
      end
      check_eq("lock_m1_count", m1_cnt, 32'd3);
      check_eq("lock_m0_gap", gap, 32'd3);
    end
`endif

    repeat (3) @(negedge clk);
    check_eq("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
